// File: rtl/store_align_buffer_if.sv
// store_align_buffer_if: pipeline store request, memory write and fault reporting bundle
interface store_align_buffer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [1:0]  in_size;
   logic        flush;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        misalign_err;
   logic [31:0] err_addr;
   logic        empty;
   modport slave (
      input  in_valid, in_addr, in_data, in_size, flush, mem_ready,
      output in_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, err_addr, empty
   );
   modport master (
      output in_valid, in_addr, in_data, in_size, flush, mem_ready,
      input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, err_addr, empty
   );
endinterface

// File: rtl/store_align_buffer.sv
// store_align_buffer: lane-aligns byte/half/word stores and queues them for data memory
module store_align_buffer #(
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst_n,
   store_align_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [3:0]    be_q   [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          accept, aligned, push, pop, err_q;
   logic [31:0]   err_addr_q, fmt_wdata;
   logic [3:0]    fmt_be;
   assign bus.in_ready = (count < (AW+1)'(DEPTH)) && !bus.flush;
   assign accept = bus.in_valid && bus.in_ready;
   assign aligned = (bus.in_size == 2'b00) ||
                    (bus.in_size == 2'b01 && !bus.in_addr[0]) ||
                    (bus.in_size == 2'b10 && bus.in_addr[1:0] == 2'b00);
   assign push = accept && aligned;
   assign pop = bus.mem_valid && bus.mem_ready;
   // Replicate the narrow value on every lane; the enables pick the lanes memory writes.
   assign fmt_wdata = bus.in_size == 2'b00 ? {4{bus.in_data[7:0]}} :
                      bus.in_size == 2'b01 ? {2{bus.in_data[15:0]}} : bus.in_data;
   assign fmt_be = bus.in_size == 2'b00 ? 4'b0001 << bus.in_addr[1:0] :
                   bus.in_size == 2'b01 ? (bus.in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign bus.mem_valid = count != '0;
   assign bus.empty = count == '0;
   assign bus.mem_addr = bus.mem_valid ? {addr_q[rd_ptr], 2'b00} : '0;
   assign bus.mem_wdata = bus.mem_valid ? data_q[rd_ptr] : '0;
   assign bus.mem_be = bus.mem_valid ? be_q[rd_ptr] : '0;
   assign bus.misalign_err = err_q;
   assign bus.err_addr = err_addr_q;
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= bus.in_addr[31:2];
         data_q[wr_ptr] <= fmt_wdata;
         be_q[wr_ptr]   <= fmt_be;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q <= accept && !aligned;
         if (accept && !aligned) err_addr_q <= bus.in_addr;
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         end
      end
   end
endmodule

// File: tb/tb_store_align_buffer.sv
// tb_store_align_buffer: queue-based reference model plus directed store, fault, flush and reset vectors
module tb_store_align_buffer;
   localparam int DEPTH = 2;
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int failures = 0;
   ent_t q[$];
   logic m_err;
   logic [31:0] m_err_addr;
   store_align_buffer_if bus();
   store_align_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic void fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                               output bit ok, output ent_t e);
      int n, off;
      n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      off = int'(a[1:0]);
      ok = (s != 2'd3) && (off % n == 0);
      e.a = a & ~32'h3;
      for (int i = 0; i < 4; i++) begin
         e.d[8*i +: 8] = d[8*(i % n) +: 8];
         e.be[i] = (i >= off) && (i < off + n);
      end
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_err = 1'b0;
         m_err_addr = '0;
      end else begin
         bit ok, rdy;
         ent_t e;
         rdy = (q.size() < DEPTH) && !bus.flush;
         fmt(bus.in_addr, bus.in_data, bus.in_size, ok, e);
         m_err = bus.in_valid && rdy && !ok;
         if (m_err) m_err_addr = bus.in_addr;
         if (bus.flush) q.delete();
         else begin
            if (q.size() > 0 && bus.mem_ready) void'(q.pop_front());
            if (bus.in_valid && rdy && ok) q.push_back(e);
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      logic v;
      v = q.size() > 0;
      chk("cyc_in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) && !bus.flush));
      chk("cyc_mem_valid", 32'(bus.mem_valid), 32'(v));
      chk("cyc_mem_addr", bus.mem_addr, v ? q[0].a : 32'h0);
      chk("cyc_mem_wdata", bus.mem_wdata, v ? q[0].d : 32'h0);
      chk("cyc_mem_be", 32'(bus.mem_be), v ? 32'(q[0].be) : 32'h0);
      chk("cyc_empty", 32'(bus.empty), 32'(!v));
      chk("cyc_misalign_err", 32'(bus.misalign_err), 32'(m_err));
      chk("cyc_err_addr", bus.err_addr, m_err_addr);
   end
   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic mr, input logic fl);
      bus.in_valid = v;
      bus.in_addr = a;
      bus.in_data = d;
      bus.in_size = s;
      bus.mem_ready = mr;
      bus.flush = fl;
      @(negedge clk);
      #1;
   endtask
   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_addr = '0;
      bus.in_data = '0;
      bus.in_size = '0;
      bus.mem_ready = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_err_addr", bus.err_addr, 32'h0);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h100 + 32'(i), 32'hA5, 2'd0, 1, 0);
         chk("byte_be", 32'(bus.mem_be), 32'(4'b0001 << i));
         chk("byte_wdata", bus.mem_wdata, 32'hA5A5A5A5);
         chk("byte_addr", bus.mem_addr, 32'h100);
      end
      step(0, 0, 0, 0, 1, 0);
      chk("byte_drained", 32'(bus.empty), 32'd1);
      step(1, 32'h202, 32'h1234BEEF, 2'd1, 0, 0);
      chk("half_be", 32'(bus.mem_be), 32'hC);
      chk("half_wdata", bus.mem_wdata, 32'hBEEFBEEF);
      chk("half_addr", bus.mem_addr, 32'h200);
      step(1, 32'h204, 32'hDEADBEEF, 2'd2, 1, 0);
      chk("word_be", 32'(bus.mem_be), 32'hF);
      chk("word_addr", bus.mem_addr, 32'h204);
      chk("word_wdata", bus.mem_wdata, 32'hDEADBEEF);
      step(0, 0, 0, 0, 1, 0);
      step(1, 32'h301, 32'h1, 2'd1, 1, 0);
      chk("mis_half_err", 32'(bus.misalign_err), 32'd1);
      chk("mis_half_addr", bus.err_addr, 32'h301);
      step(1, 32'h302, 32'h2, 2'd2, 1, 0);
      chk("mis_word_err", 32'(bus.misalign_err), 32'd1);
      chk("mis_word_addr", bus.err_addr, 32'h302);
      step(1, 32'h300, 32'h3, 2'd3, 1, 0);
      chk("mis_rsv_err", 32'(bus.misalign_err), 32'd1);
      chk("mis_rsv_addr", bus.err_addr, 32'h300);
      chk("mis_no_valid", 32'(bus.mem_valid), 32'd0);
      step(0, 0, 0, 0, 1, 0);
      chk("mis_pulse_end", 32'(bus.misalign_err), 32'd0);
      chk("mis_addr_hold", bus.err_addr, 32'h300);
      step(1, 32'h400, 32'h11, 2'd2, 0, 0);
      chk("bp_ready1", 32'(bus.in_ready), 32'd1);
      step(1, 32'h404, 32'h22, 2'd2, 0, 0);
      chk("bp_full", 32'(bus.in_ready), 32'd0);
      step(1, 32'h408, 32'h33, 2'd2, 0, 0);
      chk("bp_head_stable", bus.mem_addr, 32'h400);
      chk("bp_head_data", bus.mem_wdata, 32'h11);
      step(1, 32'h408, 32'h33, 2'd2, 1, 0);
      chk("bp_second_head", bus.mem_addr, 32'h404);
      chk("bp_ready_again", 32'(bus.in_ready), 32'd1);
      step(1, 32'h408, 32'h33, 2'd2, 1, 0);
      chk("bp_third_head", bus.mem_addr, 32'h408);
      step(0, 0, 0, 0, 1, 0);
      chk("bp_drained", 32'(bus.empty), 32'd1);
      step(1, 32'h500, 32'h44, 2'd2, 0, 0);
      step(1, 32'h504, 32'h55, 2'd2, 0, 0);
      bus.flush = 1'b1;
      #1;
      chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
      step(0, 0, 0, 0, 1, 1);
      chk("fl_empty", 32'(bus.empty), 32'd1);
      chk("fl_mem_valid", 32'(bus.mem_valid), 32'd0);
      step(1, 32'h601, 32'h0, 2'd1, 0, 0);
      bus.flush = 1'b1;
      #1;
      chk("fl_err_survives", 32'(bus.misalign_err), 32'd1);
      step(0, 0, 0, 0, 0, 1);
      chk("fl_err_addr", bus.err_addr, 32'h601);
      step(1, 32'h700, 32'h66, 2'd2, 0, 0);
      step(1, 32'h704, 32'h77, 2'd2, 0, 0);
      chk("ar_pre_valid", 32'(bus.mem_valid), 32'd1);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("ar_mem_be", 32'(bus.mem_be), 32'd0);
      chk("ar_mem_addr", bus.mem_addr, 32'h0);
      chk("ar_mem_wdata", bus.mem_wdata, 32'h0);
      chk("ar_empty", 32'(bus.empty), 32'd1);
      chk("ar_err_addr", bus.err_addr, 32'h0);
      chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
      step(0, 0, 0, 0, 1, 0);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 1, 0);
      chk("ar_no_reissue", 32'(bus.mem_valid), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/store_align_buffer.md
# store_align_buffer

Store-path counterpart to the load-side sign/zero extension in the datapath. It narrows a 32-bit register value to a byte, halfword or word store. It places the data on the correct byte lanes of a word-aligned data-memory write and generates byte enables. It buffers up to DEPTH stores behind a valid/ready handshake so the pipeline's MEM stage does not stall on a single busy memory cycle.

## Interface
Parameters:
- DEPTH, 2, number of store-buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  store request from pipeline
- in_ready  out  1  buffer can accept; combinational = (count < DEPTH) && !flush
- in_addr  in  32  byte address of store
- in_data  in  32  register value; only low byte/half used for narrow stores
- in_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- flush  in  1  synchronous discard of all buffered stores
- mem_valid  out  1  head entry present
- mem_ready  in  1  memory accepts head this cycle
- mem_addr  out  32  {in_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- misalign_err  out  1  one-cycle exception pulse
- err_addr  out  32  address of the faulting store, held until next fault
- empty  out  1  count == 0

## Operation
- Request accepted on in_valid && in_ready.
- Formatting is applied at accept time, and the formatted entry is stored:
  - byte: wdata = {4{in_data[7:0]}}, be = 4'b0001 << in_addr[1:0]
  - half: requires in_addr[0]==0; wdata = {2{in_data[15:0]}}; be = in_addr[1] ? 4'b1100 : 4'b0011
  - word: requires in_addr[1:0]==0; wdata = in_data; be = 4'b1111
- Misaligned half/word or size 11:
  - the handshake still completes, but nothing is enqueued
  - misalign_err = 1 the next cycle; err_addr = in_addr registered
- FIFO, in-order:
  - mem_* presents the head.
  - Head pops on mem_valid && mem_ready.
  - mem_addr/mem_wdata/mem_be are held stable while mem_valid && !mem_ready.
  - mem_be = 0 whenever mem_valid = 0.
- Push and pop in the same cycle: count unchanged. Since in_ready = 0 when full, a full buffer never accepts, even if it pops that cycle.
- Read/write pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits.
- flush:
  - All entries are cleared at the clock edge.
  - If mem_valid && mem_ready in the flush cycle, that head transfer counts as completed. All other entries are dropped.
  - in_ready = 0 during flush, so nothing is accepted.
  - A misalign_err already scheduled from the previous cycle still fires.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0
  - mem_valid = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0
  - misalign_err = 0, err_addr = 0, empty = 1
  - in_ready = 1 once flush is low
- Reset mid-transfer drops all entries. No partial write is re-issued.
- Latency: a store accepted at edge N drives mem_valid from edge N (visible in cycle N+1) if the buffer was empty. There is no combinational in→mem path.
- Throughput: 1 store/cycle sustained when mem_ready is held high.
- misalign_err: pulse exactly 1 cycle per faulting request. Back-to-back faults give back-to-back pulses, with err_addr updating each cycle.
- mem_ready is ignored while mem_valid = 0.

## Test plan
- Byte store sweep: addr 0x100..0x103, data 0xA5, mem_ready = 1 → be 0001, 0010, 0100, 1000; wdata 0xA5A5A5A5; mem_addr 0x100 each time, one per cycle.
- Half/word: half at 0x202, data 0x1234BEEF → be 1100, wdata 0xBEEFBEEF. Word at 0x204, data 0xDEADBEEF → be 1111, mem_addr 0x204.
- Misalign: half at 0x301, then word at 0x302, then size 11 at 0x300 → three consecutive misalign_err pulses with err_addr 0x301, 0x302, 0x300. mem_valid never asserts and count stays 0.
- Backpressure: mem_ready = 0, push 3 stores (DEPTH = 2) → in_ready falls after the 2nd. The head stays stable. Raising mem_ready drains the buffer in order, and the 3rd store is accepted the cycle after the first pop.
- Flush: 2 entries buffered, flush together with mem_ready = 1 → the head counts as transferred, the second entry is dropped, and empty = 1 next cycle.
- Async reset mid-stream: rst_n low between edges with 2 entries buffered → mem_valid = 0 and mem_be = 0 immediately, and all outputs equal their reset values.
